// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of a 4:1 mux.
// Grants are registered one-hot, with a bounded hold under contention.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       sel_1,
  output logic       sel_2,
  output logic       busy
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [1:0]    owner_q;
  logic [1:0]    owner_d;
  logic [1:0]    last_q;
  logic [1:0]    last_d;
  logic [CW-1:0] hold_q;
  logic [CW-1:0] hold_d;
  logic [3:0]    grant_q;
  logic [3:0]    grant_d;
  logic          busy_q;
  logic          busy_d;

  logic [3:0]    own_mask;
  logic [3:0]    others;
  logic          own_req;
  logic          at_lim;
  logic          any_req;
  logic          any_oth;
  logic [1:0]    win_all;
  logic [1:0]    win_oth;

  function automatic logic [3:0] onehot(
    input logic [1:0] idx
  );
    logic [3:0] v;
    v = 4'b0000;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First set bit scanning upward from last+1, wrapping 3 -> 0.
  function automatic logic [1:0] rr_pick(
    input logic [3:0] r,
    input logic [1:0] last
  );
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign own_mask = onehot(owner_q);
  assign own_req  = |(req & own_mask);
  assign others   = req & ~own_mask;
  assign at_lim   = (hold_q == HOLD_LIM);
  assign any_req  = |req;
  assign any_oth  = |others;
  assign win_all  = rr_pick(req, last_q);
  assign win_oth  = rr_pick(others, last_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      hold_q  <= '0;
      grant_q <= 4'b0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = OWNED;
          owner_d = win_all;
          last_d  = win_all;
          hold_d  = '0;
          grant_d = onehot(win_all);
          busy_d  = 1'b1;
        end
      end
      OWNED: begin
        unique case (1'b1)
          (!own_req && any_req): begin
            owner_d = win_all;
            last_d  = win_all;
            hold_d  = '0;
            grant_d = onehot(win_all);
            busy_d  = 1'b1;
          end
          (!own_req && !any_req): begin
            state_d = IDLE;
            hold_d  = '0;
            grant_d = 4'b0000;
            busy_d  = 1'b0;
          end
          (own_req && at_lim && any_oth): begin
            owner_d = win_oth;
            last_d  = win_oth;
            hold_d  = '0;
            grant_d = onehot(win_oth);
            busy_d  = 1'b1;
          end
          default: begin
            // Saturates at the limit so a late contender rotates at once.
            if (!at_lim) hold_d = hold_q + 1'b1;
          end
        endcase
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign grant = grant_q;
  assign sel_1 = owner_q[0];
  assign sel_2 = owner_q[1];
  assign busy  = busy_q;

`ifndef SYNTHESIS
  a_onehot: assert property (
    @(posedge clk) disable iff (!rst_n)
    $onehot0(grant)
  );

  a_busy: assert property (
    @(posedge clk) disable iff (!rst_n)
    busy == (grant != 4'b0000)
  );

  a_sel: assert property (
    @(posedge clk) disable iff (!rst_n)
    busy |-> (grant == onehot({sel_2, sel_1}))
  );
`endif

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares the 4-input, 1-bit mux datapath among four requesters and drives its two select lines. Requester index 0..3 maps to mux inputs A, B, C and D. The block registers one-hot grants, holds a grant while its request stays high, and forces a rotation after a bounded hold time when other requesters are waiting. It sits directly in front of the mux: its sel_1 and sel_2 outputs connect to the mux select inputs of the same name.

## Interface
- MAX_HOLD, 8: maximum consecutive cycles one owner keeps the grant while another request is pending; legal range 1..255.
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- req  input  4  request vector; bit i requests mux input i (0=A, 1=B, 2=C, 3=D).
- grant  output  4  one-hot grant, or all-zero when idle; registered.
- sel_1  output  1  mux select LSB; picks A/B and C/D within each pair; registered.
- sel_2  output  1  mux select MSB; picks the pair (0=A/B, 1=C/D); registered.
- busy  output  1  high whenever grant is non-zero; registered.

## Operation
- Owner index is {sel_2, sel_1}. While busy, grant equals one-hot(owner).
- State machine has two states: IDLE and OWNED.
  - IDLE: if req is non-zero, pick the winner by round-robin, then go to OWNED. Otherwise stay in IDLE.
  - OWNED, req[owner] drops to 0: pick the next winner from req in the same cycle (the owner's bit is low, so it is excluded) and stay in OWNED. If req is all-zero, go to IDLE. No dead cycle occurs between owners.
  - OWNED, req[owner] stays high:
    - Increment hold_cnt.
    - If hold_cnt == MAX_HOLD-1 and any other req bit is high, rotate to the next winner (excluding the owner) and clear hold_cnt.
    - If no other request is pending, hold_cnt saturates at MAX_HOLD-1 and the grant is kept.
- Round-robin rule: search starts at (last_owner+1) mod 4 and wraps 3 to 0. The first high request bit wins. last_owner updates on every new grant.
- hold_cnt is $clog2(MAX_HOLD+1) bits wide, unsigned, and clears on every new grant. With MAX_HOLD=1, contending requesters rotate every cycle.
- Outputs when idle:
  - grant is 0 and busy is 0.
  - sel_1 and sel_2 keep the last owner index, so the mux output stays stable.
- Reset (rst_n low at a rising edge):
  - State goes to IDLE.
  - grant = 4'b0000, busy = 0, sel_1 = 0, sel_2 = 0, hold_cnt = 0.
  - last_owner = 3, so index 0 has first priority.
- Reset asserted mid-ownership clears everything on that edge. Requests are ignored while rst_n is low.

## Timing
- Latency: a request sampled at edge N produces grant, sel and busy valid after edge N (one-cycle registered latency).
- Release handover: req[owner] low at edge N moves the grant to the next winner at edge N.
  - The new winner must be requesting at edge N.
  - grant is never two-hot and never changes without a rising clk edge.
- Forced rotation: an owner holding continuously from grant edge G loses the grant at edge G+MAX_HOLD, but only if another request is high at that edge.
- sel_1, sel_2 and grant change on the same edge, so the mux selects match the grant in every cycle.
- Simultaneous requests are resolved purely by the round-robin pointer. No fixed priority exists beyond reset.

## Test plan
- Reset, then req=4'b0001: after 1 edge, grant=0001, sel_2=0, sel_1=0, busy=1. Drop req: next edge grant=0000, busy=0, sel stays 00.
- req=4'b1111 held, MAX_HOLD=8, fresh reset: grants rotate 0001, 0010, 0100, 1000, 0001, each held exactly 8 cycles. Sel sequence is 00, 01, 10, 11.
- Owner 2 holds alone for 20 cycles: grant stays 0100 and hold_cnt saturates. At cycle 21 assert req[0]: grant moves to 0001 on the next edge, because the saturated counter already meets the limit.
- Owner 1 drops req while req[3] is high: grant goes from 0010 to 1000 on the same edge, with no idle cycle in between.
- Assert rst_n=0 while grant=1000: next edge gives grant=0000, sel=00, busy=0. After release with req=1111, first grant is 0001.
- MAX_HOLD=1 with req=4'b0110: grant alternates 0010, 0100 on every cycle.
